// File: rtl/simple_dir2_responder.sv
// simple_dir2_responder
//   Downstream consumer on the dir2 side of the `simple` interface. It watches
//   simple1 for value changes and queues each changed word in a small FIFO.
//   The FIFO drains at one pop every DRAIN_DIV cycles into a rotate-XOR
//   signature, which is driven back on simple2.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset, overrides every other event
//   en          capture enable for simple1 monitoring (draining ignores it)
//   simple1     observed word from the dir1 producer
//   simple2     registered rotate-XOR signature of every drained word
//   change_cnt  registered count of detected changes, saturates at 0xFFFF
//   fifo_level  registered FIFO occupancy
//   overflow    registered sticky flag: a change was dropped on a full FIFO
//   busy        combinational, fifo_level != 0
module simple_dir2_responder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DRAIN_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         simple1,
  output logic [WIDTH-1:0]         simple2,
  output logic [15:0]              change_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     busy
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DRAIN_DIV - 1);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  // Registered state
  logic [WIDTH-1:0] prev_q,       prev_d;
  logic             seeded_q,     seeded_d;
  logic [WIDTH-1:0] simple2_q,    simple2_d;
  logic [15:0]      change_cnt_q, change_cnt_d;
  logic             overflow_q,   overflow_d;
  logic [PTR_W-1:0] wptr_q,       wptr_d;
  logic [PTR_W-1:0] rptr_q,       rptr_d;
  logic [PTR_W-1:0] level_q,      level_d;
  logic [CNT_W-1:0] div_q,        div_d;

  // FIFO storage; contents are discarded on reset by clearing the pointers
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Combinational helpers
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic [WIDTH-1:0] head;

  // Full/empty from the wrap-bit pointer pair
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                 (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]);
    head       = mem_q[rptr_q[ADDR_W-1:0]];
    pop        = !fifo_empty && (div_q == DIV_LAST);
  end

  // Seeding and change detection on simple1
  always_comb begin
    prev_d       = prev_q;
    seeded_d     = seeded_q;
    change_cnt_d = change_cnt_q;
    push_req     = 1'b0;
    if (en) begin
      if (!seeded_q) begin
        // First enabled edge only captures a reference value
        prev_d   = simple1;
        seeded_d = 1'b1;
      end else if (simple1 != prev_q) begin
        prev_d   = simple1;
        push_req = 1'b1;
        if (change_cnt_q != CNT_MAX) begin
          change_cnt_d = change_cnt_q + 16'd1;
        end
      end
    end
  end

  // Push acceptance: a full FIFO still accepts when the head leaves this edge
  always_comb begin
    push_ok    = push_req && (!fifo_full || pop);
    overflow_d = overflow_q | (push_req && !push_ok);
    wptr_d     = push_ok ? (wptr_q + PTR_W'(1)) : wptr_q;
    rptr_d     = pop     ? (rptr_q + PTR_W'(1)) : rptr_q;
    level_d    = wptr_d - rptr_d;
  end

  // Drain pacing and signature update
  always_comb begin
    div_d     = div_q;
    simple2_d = simple2_q;
    if (fifo_empty) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + CNT_W'(1);
    end
    if (pop) begin
      simple2_d = {simple2_q[WIDTH-2:0], simple2_q[WIDTH-1]} ^ head;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      seeded_q     <= 1'b0;
      simple2_q    <= '0;
      change_cnt_q <= '0;
      overflow_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      div_q        <= '0;
    end else begin
      prev_q       <= prev_d;
      seeded_q     <= seeded_d;
      simple2_q    <= simple2_d;
      change_cnt_q <= change_cnt_d;
      overflow_q   <= overflow_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      div_q        <= div_d;
    end
  end

  // FIFO write port; the slot being popped is read before this write lands
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= simple1;
    end
  end

  assign simple2    = simple2_q;
  assign change_cnt = change_cnt_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign busy       = (level_q != '0);

endmodule
